mc_main_fsm: RTL and testbench

//  Multicycle main controller: sequences each instruction through fetch/decode/execute/writeback.

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/mc_perf_counters.sv | 40 ++++
 rtl/mc_main_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_main_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and constants for the multicycle main controller.
//               Holds the FSM state encoding, the supported RV32 opcodes and
//               the encodings of the datapath mux selects and ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // Main controller states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // Supported opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operand A select
  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } alu_src_a_t;

  // ALU operand B select
  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  // Result bus select
  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/mc_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : mc_perf_counters
// Description : Cycle and retired-instruction counters for the multicycle
//               controller. Both wrap modulo 2**CNT_W.
// Ports       : clk, reset (async, active-high)
//               inc_cycle   - advance cycle_cnt this cycle
//               inc_instret - advance instret_cnt this cycle
//               cycle_cnt, instret_cnt - counter values
// Revision    : 1.0 - initial release
// ============================================================================
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_cycle,
  input  logic             inc_instret,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (inc_cycle)   r_cycle   <= r_cycle + 1'b1;
      if (inc_instret) r_instret <= r_instret + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;

endmodule
`default_nettype wire

// File: rtl/mc_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_fsm
// Description : Multicycle main controller. Steps each RV32 instruction
//               (lw, sw, R-type, I-type ALU, beq, jal) through fetch, decode,
//               execute and writeback, driving the datapath flop enables and
//               mux selects. Unsupported opcodes park the FSM in ILLEGAL.
// Ports       : clk, reset (async, active-high, forces FETCH)
//               op, zero, mem_ready                       - inputs
//               pc_write, ir_write, reg_write, mem_write  - flop enables
//               adr_src, alu_src_a, alu_src_b, result_src, alu_op - selects
//               illegal                                   - sticky trap flag
//               cycle_cnt, instret_cnt                    - perf counters
// Config      : MC_FSM_PERF_EN - when defined, instantiates the perf
//               counters; otherwise the counter ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  import mc_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic        w_pc_update;
  logic        w_branch;
  logic        w_ir_write;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_adr_src;
  alu_src_a_t  w_src_a;
  alu_src_b_t  w_src_b;
  result_src_t w_res_src;
  alu_op_t     w_alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    w_adr_src   = 1'b0;
    w_src_a     = SRCA_PC;
    w_src_b     = SRCB_RD2;
    w_res_src   = RES_ALUOUT;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        // PC+4 is computed and latched in the same cycle the IR loads
        w_src_b     = SRCB_FOUR;
        w_res_src   = RES_ALURESULT;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch/jump target (old PC + imm) into ALUOut
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        w_src_a = SRCA_RD1;
        w_src_b = SRCB_IMM;
        case (op)
          OP_LW:   w_next = S_MEMREAD;
          OP_SW:   w_next = S_MEMWRITE;
          // IR is stable here, so anything else means corrupted control
          default: w_next = S_ILLEGAL;
        endcase
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res_src   = RES_DATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_src_a  = SRCA_RD1;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a  = SRCA_RD1;
        w_src_b  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_src_a  = SRCA_RD1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_JAL: begin
        // PC <- target held in ALUOut; ALU forms old PC + 4 for the link
        w_src_a     = SRCA_OLDPC;
        w_src_b     = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_ILLEGAL: begin
        w_next = S_ILLEGAL;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Enables are masked by reset so nothing pulses while reset is held,
  // even though FETCH itself would otherwise follow mem_ready.
  assign pc_write   = ~reset & (w_pc_update | (w_branch & zero));
  assign ir_write   = ~reset & w_ir_write;
  assign reg_write  = ~reset & w_reg_write;
  assign mem_write  = ~reset & w_mem_write;
  assign adr_src    = w_adr_src;
  assign alu_src_a  = w_src_a;
  assign alu_src_b  = w_src_b;
  assign result_src = w_res_src;
  assign alu_op     = w_alu_op;
  assign illegal    = (r_state == S_ILLEGAL);

`ifdef MC_FSM_PERF_EN
  logic w_inc_instret;

  // Retire on the edge that returns to FETCH after a completed instruction
  assign w_inc_instret = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                         (r_state == S_BEQ) ||
                         ((r_state == S_MEMWRITE) && mem_ready);

  mc_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk         (clk),
    .reset       (reset),
    .inc_cycle   (1'b1),
    .inc_instret (w_inc_instret),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_main_fsm
// Description : Directed self-checking bench for mc_main_fsm. Each cycle the
//               packed control vector is compared against hand-derived
//               per-state constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_fsm;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
  logic [1:0]       alu_src_a, alu_src_b, result_src, alu_op;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  mc_main_fsm #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ir_write, reg_write, mem_write, adr_src, a, b, result_src, alu_op, illegal}
  logic [13:0] w_ctrl;
  assign w_ctrl = {pc_write, ir_write, reg_write, mem_write, adr_src,
                   alu_src_a, alu_src_b, result_src, alu_op, illegal};

  localparam logic [13:0] E_FETCH_R = {4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [13:0] E_FETCH_W = {4'b0000, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [13:0] E_RST     = {4'b0000, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [13:0] E_DEC     = {4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_MADR    = {4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_MRD     = {4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_MWB     = {4'b0010, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [13:0] E_MWR     = {4'b0001, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_EXR     = {4'b0000, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [13:0] E_EXI     = {4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [13:0] E_AWB     = {4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_BEQ_T   = {4'b1000, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
  localparam logic [13:0] E_BEQ_N   = {4'b0000, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
  localparam logic [13:0] E_JAL     = {4'b1000, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_ILL     = {4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set right after a falling edge; settle, check, move on.
  task automatic cyc(input string tag, input logic [13:0] exp);
    #1;
    check(tag, {18'd0, w_ctrl}, {18'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    check("reset_ctrl", {18'd0, w_ctrl}, {18'd0, E_RST});
    @(negedge clk);
    reset = 1'b0;

    // lw, zero wait
    op = 7'b0000011; mem_ready = 1'b1;
    cyc("lw_fetch", E_FETCH_R);
    cyc("lw_decode", E_DEC);
    cyc("lw_memadr", E_MADR);
    cyc("lw_memread", E_MRD);
    cyc("lw_memwb", E_MWB);

    // sw with two wait cycles in MEMWRITE
    op = 7'b0100011;
    cyc("sw_fetch", E_FETCH_R);
    cyc("sw_decode", E_DEC);
    cyc("sw_memadr", E_MADR);
    mem_ready = 1'b0;
    cyc("sw_memwr_w1", E_MWR);
    cyc("sw_memwr_w2", E_MWR);
    mem_ready = 1'b1;
    cyc("sw_memwr_go", E_MWR);

    // beq taken then not taken
    op = 7'b1100011; zero = 1'b1;
    cyc("beqt_fetch", E_FETCH_R);
    cyc("beqt_decode", E_DEC);
    cyc("beqt_beq", E_BEQ_T);
    zero = 1'b0;
    cyc("beqn_fetch", E_FETCH_R);
    cyc("beqn_decode", E_DEC);
    cyc("beqn_beq", E_BEQ_N);

    // R-type with one fetch wait cycle
    op = 7'b0110011; mem_ready = 1'b0;
    cyc("r_fetch_wait", E_FETCH_W);
    mem_ready = 1'b1;
    cyc("r_fetch", E_FETCH_R);
    cyc("r_decode", E_DEC);
    cyc("r_exec", E_EXR);
    cyc("r_aluwb", E_AWB);

    // I-type
    op = 7'b0010011;
    cyc("i_fetch", E_FETCH_R);
    cyc("i_decode", E_DEC);
    cyc("i_exec", E_EXI);
    cyc("i_aluwb", E_AWB);

    // jal
    op = 7'b1101111;
    cyc("jal_fetch", E_FETCH_R);
    cyc("jal_decode", E_DEC);
    cyc("jal_jal", E_JAL);
    cyc("jal_aluwb", E_AWB);

    // lw aborted by reset in MEMWB
    op = 7'b0000011;
    cyc("lw2_fetch", E_FETCH_R);
    cyc("lw2_decode", E_DEC);
    cyc("lw2_memadr", E_MADR);
    cyc("lw2_memread", E_MRD);
    #1;
    check("lw2_memwb", {18'd0, w_ctrl}, {18'd0, E_MWB});
`ifdef MC_FSM_PERF_EN
    check("perf_cycle_34", cycle_cnt, 32'd34);
    check("perf_instret_7", instret_cnt, 32'd7);
`else
    check("perf_cycle_tied", cycle_cnt, 32'd0);
    check("perf_instret_tied", instret_cnt, 32'd0);
`endif
    reset = 1'b1;
    #1;
    check("rst_regwrite_drop", {31'd0, reg_write}, 32'd0);
    check("rst_ctrl", {18'd0, w_ctrl}, {18'd0, E_RST});
    @(negedge clk);
    #1;
    check("rst_hold_ctrl", {18'd0, w_ctrl}, {18'd0, E_RST});
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_illegal", {31'd0, illegal}, 32'd0);
    check("post_rst_cycle", cycle_cnt, 32'd0);
    check("post_rst_instret", instret_cnt, 32'd0);

    // illegal opcode: absorbing, sticky, no enables
    op = 7'b1111111;
    cyc("ill_fetch", E_FETCH_R);
    cyc("ill_decode", E_DEC);
    for (int i = 0; i < 100; i++) begin
      if (i == 40) op = 7'b0110011;
      cyc("ill_state", E_ILL);
    end
    #1;
`ifdef MC_FSM_PERF_EN
    check("ill_cycle_adv", cycle_cnt, 32'd102);
    check("ill_instret_frozen", instret_cnt, 32'd0);
`else
    check("ill_cycle_tied", cycle_cnt, 32'd0);
    check("ill_instret_tied", instret_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
